// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared FSM state type, instruction payload struct,
// opcode field positions and the 6502 instruction-length decoder.
package fetch_unit_pkg;

    // Default first fetch address after reset.
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h8000;

    // Opcode field positions: aaa_bbb_cc.
    localparam int CC_LSB  = 0;
    localparam int CC_MSB  = 1;
    localparam int BBB_LSB = 2;
    localparam int BBB_MSB = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH_OP = 3'd1,
        ST_FETCH_LO = 3'd2,
        ST_FETCH_HI = 3'd3,
        ST_HOLD     = 3'd4
    } fetch_state_t;

    // One assembled instruction as seen by the decoder.
    typedef struct packed {
        logic [7:0]  opcode;
        logic [15:0] data;
        logic [1:0]  len;
        logic [15:0] pc;
    } instr_t;

    // Instruction length in bytes (1..3) from the opcode's cc/bbb groups.
    // cc=11 opcodes are illegal on the 6502 and are passed through as 1 byte.
    function automatic logic [1:0] instr_len(input logic [7:0] op);
        logic [1:0] cc;
        logic [2:0] bbb;
        logic [1:0] len;
        cc  = op[CC_MSB:CC_LSB];
        bbb = op[BBB_MSB:BBB_LSB];
        len = 2'd2;
        case (cc)
            2'b01: begin
                if (bbb == 3'b011 || bbb == 3'b110 || bbb == 3'b111)
                    len = 2'd3;
            end
            2'b10: begin
                if (bbb == 3'b010 || bbb == 3'b100 || bbb == 3'b110)
                    len = 2'd1;
                else if (bbb == 3'b011 || bbb == 3'b111)
                    len = 2'd3;
            end
            2'b00: begin
                if (bbb == 3'b000) begin
                    // JSR abs is the only 3-byte op in this column; BRK/RTI/RTS are implied.
                    if (op == 8'h20)
                        len = 2'd3;
                    else if (op == 8'h00 || op == 8'h40 || op == 8'h60)
                        len = 2'd1;
                end else if (bbb == 3'b010 || bbb == 3'b110) begin
                    len = 2'd1;
                end else if (bbb == 3'b011 || bbb == 3'b111) begin
                    len = 2'd3;
                end
            end
            default: len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/fetch_instr_buf.sv
// fetch_instr_buf: one-entry valid/ready register holding an assembled
// instruction. A new entry may be loaded in the same cycle the current one
// leaves, so a chain of these can stream one instruction per cycle.
module fetch_instr_buf
    import fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   rstn,
    input  logic   flush,
    input  logic   in_valid,
    input  instr_t in_instr,
    output logic   out_valid,
    input  logic   out_ready,
    output instr_t out_instr
);

    logic   valid_reg;
    instr_t instr_reg;
    logic   load;

    assign load      = in_valid & (~valid_reg | out_ready);
    assign out_valid = valid_reg;
    assign out_instr = instr_reg;

    // Entry state: flush wins, then load, then drain on consumer ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_reg <= 1'b0;
            instr_reg <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
            instr_reg <= in_instr;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: fetches 6502 instruction bytes from memory, sizes each
// instruction from its opcode, assembles opcode + operands and presents them
// to the decoder over a valid/ready handshake. redirect_i flushes everything
// and restarts fetch at redirect_pc_i.
// Optional: define FETCH_SKID_EN for a second instruction buffer so fetch
// continues while the decoder stalls.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        mem_req_o,
    output logic [15:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [7:0]  opcode_o,
    output logic [15:0] data_o,
    output logic [1:0]  len_o,
    output logic [15:0] instr_pc_o,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i
);

    fetch_state_t state_reg, state_next;
    logic [15:0]  pc_reg, pc_next;
    logic [7:0]   asm_opcode_reg;
    logic [1:0]   asm_len_reg;
    logic [15:0]  asm_pc_reg;
    logic [7:0]   asm_lo_reg;

    logic         fetching;
    logic         ack_ok;
    logic [1:0]   op_len;
    logic         complete;
    instr_t       new_instr;
    logic         hold_next;

    logic         out_in_valid;
    instr_t       out_in_instr;
    logic         out_valid;
    logic         out_ready;
    instr_t       out_instr;
    logic         out_xfer;

    assign fetching  = (state_reg == ST_FETCH_OP) || (state_reg == ST_FETCH_LO) ||
                       (state_reg == ST_FETCH_HI);
    // A redirect in the same cycle discards whatever byte memory returns.
    assign ack_ok    = fetching & mem_ack_i & ~redirect_i;
    assign op_len    = instr_len(mem_rdata_i);
    assign out_ready = instr_ready_i & ~redirect_i;
    assign out_xfer  = out_valid & out_ready;

    // Build the finished instruction from the byte arriving now plus the assembly registers.
    always_comb begin
        new_instr = '0;
        complete  = 1'b0;
        case (state_reg)
            ST_FETCH_OP: begin
                new_instr.opcode = mem_rdata_i;
                new_instr.len    = op_len;
                new_instr.pc     = pc_reg;
                complete         = ack_ok && (op_len == 2'd1);
            end
            ST_FETCH_LO: begin
                new_instr.opcode = asm_opcode_reg;
                new_instr.data   = {8'h00, mem_rdata_i};
                new_instr.len    = asm_len_reg;
                new_instr.pc     = asm_pc_reg;
                complete         = ack_ok && (asm_len_reg == 2'd2);
            end
            ST_FETCH_HI: begin
                new_instr.opcode = asm_opcode_reg;
                new_instr.data   = {mem_rdata_i, asm_lo_reg};
                new_instr.len    = asm_len_reg;
                new_instr.pc     = asm_pc_reg;
                complete         = ack_ok;
            end
            default: ;
        endcase
    end

`ifdef FETCH_SKID_EN
    logic   skid_valid;
    logic   skid_in_valid;
    instr_t skid_instr;
    logic   out_can_take;

    // The output entry accepts when empty or draining this cycle; the skid
    // entry always has priority into it to keep program order.
    assign out_can_take  = ~out_valid | out_ready;
    assign skid_in_valid = complete & (skid_valid | ~out_can_take);
    assign out_in_valid  = skid_valid | complete;
    assign out_in_instr  = skid_valid ? skid_instr : new_instr;
    // Landing in the skid entry means both entries are full next cycle.
    assign hold_next     = skid_in_valid;

    fetch_instr_buf u_skid_buf (
        .clk       (clk_i),
        .rstn      (rstn_i),
        .flush     (redirect_i),
        .in_valid  (skid_in_valid),
        .in_instr  (new_instr),
        .out_valid (skid_valid),
        .out_ready (out_can_take),
        .out_instr (skid_instr)
    );
`else
    // Single entry: fetch stops until the decoder takes the instruction.
    assign out_in_valid = complete;
    assign out_in_instr = new_instr;
    assign hold_next    = 1'b1;
`endif

    fetch_instr_buf u_out_buf (
        .clk       (clk_i),
        .rstn      (rstn_i),
        .flush     (redirect_i),
        .in_valid  (out_in_valid),
        .in_instr  (out_in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr)
    );

    // Next-state and next-pc: redirect overrides every other transition.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        if (redirect_i) begin
            state_next = ST_FETCH_OP;
            pc_next    = redirect_pc_i;
        end else begin
            if (ack_ok)
                pc_next = pc_reg + 16'd1;
            case (state_reg)
                ST_IDLE: state_next = ST_FETCH_OP;
                ST_FETCH_OP: begin
                    if (ack_ok) begin
                        if (op_len == 2'd1)
                            state_next = hold_next ? ST_HOLD : ST_FETCH_OP;
                        else
                            state_next = ST_FETCH_LO;
                    end
                end
                ST_FETCH_LO: begin
                    if (ack_ok) begin
                        if (asm_len_reg == 2'd2)
                            state_next = hold_next ? ST_HOLD : ST_FETCH_OP;
                        else
                            state_next = ST_FETCH_HI;
                    end
                end
                ST_FETCH_HI: begin
                    if (ack_ok)
                        state_next = hold_next ? ST_HOLD : ST_FETCH_OP;
                end
                ST_HOLD: begin
                    if (out_xfer)
                        state_next = ST_FETCH_OP;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // FSM state and fetch pointer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg <= ST_IDLE;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Partial-instruction assembly registers, written on accepted bytes only.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            asm_opcode_reg <= 8'h00;
            asm_len_reg    <= 2'd0;
            asm_pc_reg     <= 16'h0000;
            asm_lo_reg     <= 8'h00;
        end else if (ack_ok) begin
            case (state_reg)
                ST_FETCH_OP: begin
                    asm_opcode_reg <= mem_rdata_i;
                    asm_len_reg    <= op_len;
                    asm_pc_reg     <= pc_reg;
                end
                ST_FETCH_LO: asm_lo_reg <= mem_rdata_i;
                default: ;
            endcase
        end
    end

    // Address is driven only with a request so every output idles at zero.
    assign mem_req_o     = fetching;
    assign mem_addr_o    = fetching ? pc_reg : 16'h0000;
    assign instr_valid_o = out_valid & ~redirect_i;
    assign opcode_o      = out_instr.opcode;
    assign data_o        = out_instr.data;
    assign len_o         = out_instr.len;
    assign instr_pc_o    = out_instr.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test of fetch_unit against a zero-wait byte memory.
// Sections specific to FETCH_SKID_EN are selected with the same macro.
module tb_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [7:0]  opcode_o;
    logic [15:0] data_o;
    logic [1:0]  len_o;
    logic [15:0] instr_pc_o;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;

    logic [7:0]  mem [0:65535];
    logic        ack_en;

    int checks = 0;
    int errors = 0;

    fetch_unit #(.RESET_PC(16'h8000)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .opcode_o      (opcode_o),
        .data_o        (data_o),
        .len_o         (len_o),
        .instr_pc_o    (instr_pc_o),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    always #5 clk_i = ~clk_i;

    // Zero-wait memory: ack in the request cycle, data combinational.
    assign mem_ack_i   = mem_req_o & ack_en;
    assign mem_rdata_i = mem[mem_addr_o];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Pulse redirect for one clock; returns on the next falling edge.
    task automatic redirect_to(input logic [15:0] addr);
        redirect_i    = 1'b1;
        redirect_pc_i = addr;
        @(negedge clk_i);
        redirect_i    = 1'b0;
    endtask

    // Wait (bounded) for a valid instruction, check it, then accept it.
    task automatic expect_instr(input string tag, input logic [15:0] pc, input logic [7:0] op,
                                input logic [15:0] d, input logic [1:0] len);
        int n;
        n = 0;
        #1;
        while (!instr_valid_o && n < 12) begin
            @(negedge clk_i);
            n++;
        end
        check_eq({tag, "_valid"}, 32'(instr_valid_o), 32'd1);
        check_eq({tag, "_op"},    32'(opcode_o),      32'(op));
        check_eq({tag, "_data"},  32'(data_o),        32'(d));
        check_eq({tag, "_len"},   32'(len_o),         32'(len));
        check_eq({tag, "_pc"},    32'(instr_pc_o),    32'(pc));
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        instr_ready_i = 1'b0;
    endtask

    // Opcode sizing table: JSR, RTS, ASL A, LDX abs,Y, illegal cc=11.
    logic [7:0] op_tab  [5] = '{8'h20, 8'h60, 8'h0A, 8'hBE, 8'h03};
    logic [1:0] len_tab [5] = '{2'd3,  2'd1,  2'd1,  2'd3,  2'd1};

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] base;
        logic [15:0] exp_d;
        rstn_i        = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 16'h0000;
        instr_ready_i = 1'b0;
        ack_en        = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h8000] = 8'hA9;
        mem[16'h8001] = 8'h42;

        // Reset, with a redirect asserted that must be ignored.
        repeat (2) @(negedge clk_i);
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h1234;
        #1;
        check_eq("rst_valid",  32'(instr_valid_o), 32'd0);
        check_eq("rst_req",    32'(mem_req_o),     32'd0);
        check_eq("rst_opcode", 32'(opcode_o),      32'd0);
        check_eq("rst_data",   32'(data_o),        32'd0);
        check_eq("rst_len",    32'(len_o),         32'd0);
        check_eq("rst_ipc",    32'(instr_pc_o),    32'd0);
        @(negedge clk_i);
        redirect_i = 1'b0;
        rstn_i     = 1'b1;

        // LDA #$42 from RESET_PC.
        @(negedge clk_i);
        check_eq("a9_req1",  32'(mem_req_o),  32'd1);
        check_eq("a9_addr1", 32'(mem_addr_o), 32'h8000);
        @(negedge clk_i);
        check_eq("a9_addr2", 32'(mem_addr_o), 32'h8001);
        check_eq("a9_nvld",  32'(instr_valid_o), 32'd0);
        @(negedge clk_i);
        check_eq("a9_valid", 32'(instr_valid_o), 32'd1);
        check_eq("a9_op",    32'(opcode_o),   32'hA9);
        check_eq("a9_data",  32'(data_o),     32'h0042);
        check_eq("a9_len",   32'(len_o),      32'd2);
        check_eq("a9_ipc",   32'(instr_pc_o), 32'h8000);
`ifndef FETCH_SKID_EN
        check_eq("a9_hold_req", 32'(mem_req_o), 32'd0);
`endif

        // JMP $1234 at 8000 after a redirect; valid is masked during redirect.
        mem[16'h8000] = 8'h4C;
        mem[16'h8001] = 8'h34;
        mem[16'h8002] = 8'h12;
        redirect_i    = 1'b1;
        redirect_pc_i = 16'h8000;
        #1;
        check_eq("rd_mask", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i);
        redirect_i = 1'b0;
        #1;
        check_eq("rd_flush", 32'(instr_valid_o), 32'd0);
        check_eq("rd_addr",  32'(mem_addr_o),    32'h8000);
        begin
            int n;
            n = 0;
            while (!instr_valid_o && n < 12) begin
                @(negedge clk_i);
                n++;
            end
        end
        check_eq("4c_op",   32'(opcode_o),   32'h4C);
        check_eq("4c_data", 32'(data_o),     32'h1234);
        check_eq("4c_len",  32'(len_o),      32'd3);
        check_eq("4c_ipc",  32'(instr_pc_o), 32'h8000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            check_eq("4c_stall_valid", 32'(instr_valid_o), 32'd1);
            check_eq("4c_stall_op",    32'(opcode_o),      32'h4C);
            check_eq("4c_stall_data",  32'(data_o),        32'h1234);
`ifndef FETCH_SKID_EN
            check_eq("4c_stall_req",   32'(mem_req_o),     32'd0);
`endif
        end
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        instr_ready_i = 1'b0;
`ifndef FETCH_SKID_EN
        check_eq("4c_after_valid", 32'(instr_valid_o), 32'd0);
        check_eq("4c_after_addr",  32'(mem_addr_o),    32'h8003);
`endif

        // NOP at FFFF: pc wraps to 0000.
        mem[16'hFFFF] = 8'hEA;
        redirect_to(16'hFFFF);
        check_eq("ea_addr", 32'(mem_addr_o), 32'hFFFF);
        @(negedge clk_i);
        check_eq("ea_valid", 32'(instr_valid_o), 32'd1);
        check_eq("ea_op",    32'(opcode_o),      32'hEA);
        check_eq("ea_len",   32'(len_o),         32'd1);
        check_eq("ea_data",  32'(data_o),        32'h0000);
        check_eq("ea_ipc",   32'(instr_pc_o),    32'hFFFF);
`ifdef FETCH_SKID_EN
        check_eq("ea_wrap_addr", 32'(mem_addr_o), 32'h0000);
`endif
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        instr_ready_i = 1'b0;
`ifndef FETCH_SKID_EN
        check_eq("ea_wrap_addr", 32'(mem_addr_o), 32'h0000);
`endif

        // Redirect coincident with the LO-byte ack: byte dropped.
        mem[16'h9000] = 8'hA9;
        mem[16'h9001] = 8'h55;
        mem[16'hC000] = 8'h20;
        mem[16'hC001] = 8'h34;
        mem[16'hC002] = 8'h12;
        redirect_to(16'h9000);
        check_eq("lo_op_addr", 32'(mem_addr_o), 32'h9000);
        @(negedge clk_i);
        check_eq("lo_addr", 32'(mem_addr_o), 32'h9001);
        redirect_i    = 1'b1;
        redirect_pc_i = 16'hC000;
        #1;
        check_eq("lo_rd_valid", 32'(instr_valid_o), 32'd0);
        @(negedge clk_i);
        redirect_i = 1'b0;
        #1;
        check_eq("lo_post_valid", 32'(instr_valid_o), 32'd0);
        check_eq("lo_post_req",   32'(mem_req_o),     32'd1);
        check_eq("lo_post_addr",  32'(mem_addr_o),    32'hC000);
        expect_instr("jsr_c000", 16'hC000, 8'h20, 16'h1234, 2'd3);

        // Length decoding across opcode groups.
        for (int i = 0; i < 5; i++) begin
            base = 16'hD000 + 16'(i * 16);
            mem[base]         = op_tab[i];
            mem[base + 16'd1] = 8'h11;
            mem[base + 16'd2] = 8'h22;
            exp_d = (len_tab[i] == 2'd1) ? 16'h0000 :
                    (len_tab[i] == 2'd2) ? 16'h0011 : 16'h2211;
            redirect_to(base);
            expect_instr($sformatf("len_%02h", op_tab[i]), base, op_tab[i], exp_d, len_tab[i]);
        end

`ifdef FETCH_SKID_EN
        // Two 1-byte instructions fill output and skid while stalled.
        mem[16'hA000] = 8'hEA;
        mem[16'hA001] = 8'h18;
        mem[16'hA002] = 8'hEA;
        redirect_to(16'hA000);
        check_eq("sk_addr0", 32'(mem_addr_o), 32'hA000);
        @(negedge clk_i);
        check_eq("sk_addr1", 32'(mem_addr_o), 32'hA001);
        @(negedge clk_i);
        check_eq("sk_full_req", 32'(mem_req_o), 32'd0);
        @(negedge clk_i);
        check_eq("sk_full_req2", 32'(mem_req_o),     32'd0);
        check_eq("sk_out_valid", 32'(instr_valid_o), 32'd1);
        check_eq("sk_out_op",    32'(opcode_o),      32'hEA);
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        check_eq("sk_b2b_valid", 32'(instr_valid_o), 32'd1);
        check_eq("sk_b2b_op",    32'(opcode_o),      32'h18);
        check_eq("sk_b2b_ipc",   32'(instr_pc_o),    32'hA001);
        @(negedge clk_i);
        check_eq("sk_next_valid", 32'(instr_valid_o), 32'd1);
        check_eq("sk_next_ipc",   32'(instr_pc_o),    32'hA002);
        instr_ready_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
